// File: rtl/serv_immdec_pkg.sv
// rtl/serv_immdec_pkg.sv - Shared types and format decode for the immediate decoder sequencer.
package serv_immdec_pkg;

    typedef enum logic [2:0] {
        FMT_I   = 3'd0,
        FMT_S   = 3'd1,
        FMT_B   = 3'd2,
        FMT_U   = 3'd3,
        FMT_J   = 3'd4,
        FMT_CSR = 3'd5
    } fmt_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam logic [3:0] EN_I     = 4'b1100;
    localparam logic [3:0] EN_S     = 4'b1001;
    localparam logic [3:0] EN_B     = 4'b1001;
    localparam logic [3:0] EN_U     = 4'b0010;
    localparam logic [3:0] EN_J     = 4'b1110;
    localparam logic [3:0] EN_CSR   = 4'b0010;

    localparam logic [3:0] CTRL_I   = 4'b0000;
    localparam logic [3:0] CTRL_S   = 4'b0001;
    localparam logic [3:0] CTRL_B   = 4'b0101;
    localparam logic [3:0] CTRL_U   = 4'b1010;
    localparam logic [3:0] CTRL_J   = 4'b0000;
    localparam logic [3:0] CTRL_CSR = 4'b0000;

    typedef struct packed {
        logic [3:0] immdec_en;
        logic [3:0] ctrl;
        logic       csr_imm_en;
    } fmt_dec_t;

    // Unassigned codes 6 and 7 fall through to the I-format encoding.
    function automatic fmt_dec_t fmt_decode(input logic [2:0] fmt);
        fmt_dec_t d;
        d = '{immdec_en: EN_I, ctrl: CTRL_I, csr_imm_en: 1'b0};
        case (fmt)
            FMT_S:   d = '{immdec_en: EN_S,   ctrl: CTRL_S,   csr_imm_en: 1'b0};
            FMT_B:   d = '{immdec_en: EN_B,   ctrl: CTRL_B,   csr_imm_en: 1'b0};
            FMT_U:   d = '{immdec_en: EN_U,   ctrl: CTRL_U,   csr_imm_en: 1'b0};
            FMT_J:   d = '{immdec_en: EN_J,   ctrl: CTRL_J,   csr_imm_en: 1'b0};
            FMT_CSR: d = '{immdec_en: EN_CSR, ctrl: CTRL_CSR, csr_imm_en: 1'b1};
            default: d = '{immdec_en: EN_I,   ctrl: CTRL_I,   csr_imm_en: 1'b0};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/serv_shift_cnt.sv
// rtl/serv_shift_cnt.sv - Free-wrapping serial shift counter with last-count flag.
module serv_shift_cnt #(
    parameter int WIDTH = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_clr,
    input  logic                     i_en,
    output logic [$clog2(WIDTH)-1:0] o_cnt,
    output logic                     o_last
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // WIDTH is a power of two, so the increment wraps to 0 on its own.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt  = cnt_q;
    assign o_last = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/serv_immdec_seq.sv
// rtl/serv_immdec_seq.sv - Load arbiter and serial shift sequencer for the immediate decoder.
module serv_immdec_seq
    import serv_immdec_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ibus_ack,
    input  logic [31:0] i_ibus_rdt,
    input  logic        i_vpu_req,
    input  logic [4:0]  i_vpu_rd,
    output logic        o_vpu_gnt,
    input  logic        i_run,
    input  logic [2:0]  i_fmt,
    output logic        o_wb_en,
    output logic        o_vpu_load,
    output logic [24:0] o_wb_rdt,
    output logic        o_cnt_en,
    output logic        o_cnt_done,
    output logic [3:0]  o_immdec_en,
    output logic [3:0]  o_ctrl,
    output logic        o_csr_imm_en,
    output logic        o_busy,
    output logic        o_done
);

    state_e      state_q, state_d;
    logic        skid_vld_q, skid_vld_d;
    // Only bits 31:7 ever reach the decoder, so only those are held.
    logic [24:0] skid_word_q, skid_word_d;
    logic [2:0]  fmt_q, fmt_d;
    logic        done_q, done_d;

    logic        in_shift;
    logic        cnt_clr;
    logic        cnt_last;
    logic [$clog2(WIDTH)-1:0] unused_cnt;
    logic        unused_rdt_lo;
    fmt_dec_t    dec;

    assign in_shift      = (state_q == ST_SHIFT);
    assign unused_rdt_lo = ^i_ibus_rdt[6:0];

    serv_shift_cnt #(
        .WIDTH (WIDTH)
    ) u_shift_cnt (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (cnt_clr),
        .i_en   (in_shift),
        .o_cnt  (unused_cnt),
        .o_last (cnt_last)
    );

    always_comb begin
        state_d     = state_q;
        skid_vld_d  = skid_vld_q;
        skid_word_d = skid_word_q;
        fmt_d       = fmt_q;
        cnt_clr     = 1'b0;
        done_d      = in_shift && cnt_last;
        o_wb_en     = 1'b0;
        o_vpu_load  = 1'b0;
        o_vpu_gnt   = 1'b0;
        o_wb_rdt    = '0;

        case (state_q)
            ST_IDLE: begin
                // Loads are suppressed while reset is held so nothing leaks into the decoder.
                if (!i_rst) begin
                    if (skid_vld_q) begin
                        o_wb_en    = 1'b1;
                        o_wb_rdt   = skid_word_q;
                        skid_vld_d = 1'b0;
                        if (i_ibus_ack) begin
                            skid_vld_d  = 1'b1;
                            skid_word_d = i_ibus_rdt[31:7];
                        end
                    end else if (i_ibus_ack) begin
                        o_wb_en  = 1'b1;
                        o_wb_rdt = i_ibus_rdt[31:7];
                    end else if (i_vpu_req) begin
                        o_vpu_gnt  = 1'b1;
                        o_vpu_load = 1'b1;
                        o_wb_rdt   = {20'b0, i_vpu_rd};
                    end else if (i_run) begin
                        fmt_d   = i_fmt;
                        cnt_clr = 1'b1;
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                if (cnt_last) begin
                    state_d = ST_IDLE;
                end
                if (i_ibus_ack && !skid_vld_q) begin
                    skid_vld_d  = 1'b1;
                    skid_word_d = i_ibus_rdt[31:7];
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            skid_vld_q  <= 1'b0;
            skid_word_q <= '0;
            fmt_q       <= FMT_I;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            skid_vld_q  <= skid_vld_d;
            skid_word_q <= skid_word_d;
            fmt_q       <= fmt_d;
            done_q      <= done_d;
        end
    end

    assign dec          = fmt_decode(fmt_q);
    assign o_cnt_en     = in_shift;
    assign o_cnt_done   = in_shift && cnt_last;
    assign o_immdec_en  = in_shift ? dec.immdec_en : 4'b0000;
    assign o_ctrl       = in_shift ? dec.ctrl : 4'b0000;
    assign o_csr_imm_en = in_shift && dec.csr_imm_en;
    assign o_busy       = in_shift || skid_vld_q;
    assign o_done       = done_q;

    skid_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
        !(in_shift && skid_vld_q && i_ibus_ack));

endmodule
